// File: rtl/ram_if_pkg.sv
// Shared types and defaults for the single-port RAM initiator.
// Holds the controller state encoding and the default geometry.
package ram_if_pkg;

   localparam int unsigned AW_DEF      = 6;
   localparam int unsigned DW_DEF      = 16;
   localparam logic [15:0] CLR_VAL_DEF = 16'h0000;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StClear  = 2'd1,
      StRdWait = 2'd2,
      StRsp    = 2'd3
   } state_e;

endpackage

// File: rtl/ram_clear_counter.sv
// Address sweep counter for the clear engine.
// start_i reloads zero and wins over en_i; last_o flags the all-ones address.
module ram_clear_counter import ram_if_pkg::*; #(
   parameter int unsigned AW = AW_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start_i,
   input  logic          en_i,
   output logic [AW-1:0] cnt_o,
   output logic          last_o
);

   logic [AW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign last_o = &cnt_q;

endmodule

// File: rtl/ram_1port_master.sv
// Initiator for a single-port RAM: CPU word requests, fixed-latency reads and
// a sequential clear engine. Every output comes straight from a register.
module ram_1port_master import ram_if_pkg::*; #(
   parameter int unsigned   AW           = AW_DEF,
   parameter int unsigned   DW           = DW_DEF,
   parameter int unsigned   RD_LAT       = 1,
   parameter logic [DW-1:0] CLR_VAL      = DW'(CLR_VAL_DEF),
   parameter bit            CLR_ON_RESET = 1'b1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   input  logic          clr_start,
   output logic          busy,
   output logic [AW-1:0] ram_address,
   output logic [DW-1:0] ram_data,
   output logic          ram_wren,
   input  logic [DW-1:0] ram_q
);

   localparam int unsigned LatW = $clog2(RD_LAT + 1);

   state_e          state_q, state_d;
   logic            pend_q, pend_d;
   logic [LatW-1:0] lat_q, lat_d;
   logic            ready_q, ready_d;
   logic            busy_q, busy_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            wren_q, wren_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   data_q, data_d;

   logic            accept, clr_req;
   logic            cnt_start, cnt_en, cnt_last;
   logic [AW-1:0]   cnt;

   ram_clear_counter #(
      .AW (AW)
   ) u_clear_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .start_i (cnt_start),
      .en_i    (cnt_en),
      .cnt_o   (cnt),
      .last_o  (cnt_last)
   );

   // ready_q is only ever high in StIdle, so it also qualifies clr_start.
   assign accept  = req_valid & ready_q;
   assign clr_req = clr_start & ready_q;

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      lat_d       = lat_q;
      ready_d     = ready_q;
      busy_d      = busy_q;
      rsp_valid_d = rsp_valid_q;
      rdata_d     = rdata_q;
      wren_d      = 1'b0;
      addr_d      = addr_q;
      data_d      = data_q;
      cnt_start   = 1'b0;
      cnt_en      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               addr_d = req_addr;
               pend_d = clr_req;
               if (req_we) begin
                  wren_d  = 1'b1;
                  data_d  = req_wdata;
                  ready_d = ~clr_req;
                  busy_d  = 1'b0;
               end else begin
                  lat_d   = LatW'(RD_LAT);
                  state_d = StRdWait;
                  ready_d = 1'b0;
                  busy_d  = 1'b1;
               end
            end else if (clr_req || pend_q) begin
               state_d   = StClear;
               cnt_start = 1'b1;
               pend_d    = 1'b0;
               ready_d   = 1'b0;
               busy_d    = 1'b1;
            end else begin
               ready_d = 1'b1;
               busy_d  = 1'b0;
            end
         end
         StClear: begin
            wren_d  = 1'b1;
            addr_d  = cnt;
            data_d  = CLR_VAL;
            cnt_en  = 1'b1;
            busy_d  = 1'b1;
            ready_d = 1'b0;
            // busy drops together with wren on the edge after the last write.
            if (cnt_last) begin
               state_d = StIdle;
            end
         end
         StRdWait: begin
            if (lat_q == '0) begin
               rsp_valid_d = 1'b1;
               rdata_d     = ram_q;
               state_d     = StRsp;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         StRsp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (pend_q) begin
                  state_d   = StClear;
                  cnt_start = 1'b1;
                  pend_d    = 1'b0;
                  busy_d    = 1'b1;
               end else begin
                  state_d = StIdle;
                  ready_d = 1'b1;
                  busy_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= CLR_ON_RESET ? StClear : StIdle;
         pend_q      <= 1'b0;
         lat_q       <= '0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         wren_q      <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         lat_q       <= lat_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         wren_q      <= wren_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
      end
   end

   assign req_ready   = ready_q;
   assign busy        = busy_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rdata_q;
   assign ram_wren    = wren_q;
   assign ram_address = addr_q;
   assign ram_data    = data_q;

endmodule

// File: tb/tb_ram_1port_master.sv
// Bench for ram_1port_master with a behavioural RAM macro and a transaction
// model; directed scenarios followed by randomized traffic.
module tb_ram_1port_master;

   localparam int unsigned AW           = 6;
   localparam int unsigned DW           = 16;
   localparam int unsigned RD_LAT       = 1;
   localparam int unsigned DEPTH        = 64;
   localparam logic [15:0] CLR_VAL      = 16'h0000;
   localparam bit          CLR_ON_RESET = 1'b1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          clr_start, busy;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data;
   logic          ram_wren;
   logic [DW-1:0] ram_q;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ram_1port_master #(
      .AW           (AW),
      .DW           (DW),
      .RD_LAT       (RD_LAT),
      .CLR_VAL      (CLR_VAL),
      .CLR_ON_RESET (CLR_ON_RESET)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .clr_start   (clr_start),
      .busy        (busy),
      .ram_address (ram_address),
      .ram_data    (ram_data),
      .ram_wren    (ram_wren),
      .ram_q       (ram_q)
   );

   // RAM macro: synchronous write, read data RD_LAT clocks after the address edge.
   logic [DW-1:0] ram_mem [DEPTH];
   logic [DW-1:0] q_pipe  [RD_LAT];

   always @(posedge clk) begin
      if (ram_wren) ram_mem[ram_address] <= ram_data;
      q_pipe[0] <= ram_mem[ram_address];
      for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
   end
   assign ram_q = q_pipe[RD_LAT-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: memory image plus expected outputs after each edge.
   logic [DW-1:0] ref_mem [DEPTH];
   logic          e_ready, e_busy, e_rsp_valid, e_wren;
   logic [DW-1:0] e_rdata, e_data, rd_data;
   logic [AW-1:0] e_addr;
   bit            model_on = 1'b0;
   bit            rd_active, pend;
   int            cyc = 0;
   int            rsp_due = -1;
   int            clr_idx = -1;

   initial begin
      bit acc, start;
      forever begin
         @(posedge clk);
         cyc++;
         if (!reset_n) begin
            e_ready = 0; e_busy = 0; e_rsp_valid = 0; e_rdata = '0;
            e_wren = 0; e_addr = '0; e_data = '0;
            clr_idx = CLR_ON_RESET ? 0 : -1;
            rsp_due = -1; pend = 0; rd_active = 0;
         end else begin
            acc    = req_valid && e_ready;
            start  = clr_start && e_ready;
            e_wren = 0;
            if (e_ready) begin
               if (acc && req_we) begin
                  ref_mem[req_addr] = req_wdata;
                  e_wren = 1; e_addr = req_addr; e_data = req_wdata;
                  if (start) begin pend = 1; e_ready = 0; end
               end else if (acc) begin
                  rd_data = ref_mem[req_addr];
                  e_addr = req_addr; rd_active = 1;
                  rsp_due = cyc + RD_LAT + 1;
                  e_busy = 1; e_ready = 0; pend = start;
               end else if (start) begin
                  clr_idx = 0; e_busy = 1; e_ready = 0;
               end
            end else if (rsp_due >= 0) begin
               if (rsp_due == cyc) begin
                  e_rsp_valid = 1; e_rdata = rd_data; rsp_due = -1; rd_active = 0;
               end
            end else if (e_rsp_valid) begin
               if (rsp_ready) begin
                  e_rsp_valid = 0;
                  if (pend) begin pend = 0; clr_idx = 0; e_busy = 1; end
                  else begin e_busy = 0; e_ready = 1; end
               end
            end else if (pend) begin
               pend = 0; clr_idx = 0; e_busy = 1;
            end else if (clr_idx >= 0 && clr_idx < DEPTH) begin
               ref_mem[clr_idx] = CLR_VAL;
               e_wren = 1; e_addr = AW'(clr_idx); e_data = CLR_VAL; e_busy = 1;
               clr_idx++;
            end else begin
               clr_idx = -1; e_busy = 0; e_ready = 1;
            end
         end
         model_on = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         chk("req_ready", req_ready, e_ready);
         chk("busy", busy, e_busy);
         chk("rsp_valid", rsp_valid, e_rsp_valid);
         chk("rsp_rdata", rsp_rdata, e_rdata);
         chk("ram_wren", ram_wren, e_wren);
         if (e_wren) begin
            chk("wr_address", ram_address, e_addr);
            chk("wr_data", ram_data, e_data);
         end else if (rd_active) begin
            chk("rd_address", ram_address, e_addr);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ready(input int bound);
      int n = 0;
      while (!req_ready && n < bound) begin tick(); n++; end
      if (!req_ready) chk("ready_timeout", req_ready, 1);
   endtask

   task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit clr, input int hold,
                        output logic [DW-1:0] rd, output int lat);
      wait_ready(200);
      req_valid = 1; req_we = we; req_addr = a; req_wdata = d; clr_start = clr;
      tick();
      req_valid = 0; clr_start = 0;
      rd = '0; lat = 0;
      if (!we) begin
         do begin tick(); lat++; end while (!rsp_valid && lat < 50);
         chk("rsp_timeout", rsp_valid, 1);
         rd = rsp_rdata;
         repeat (hold) begin
            tick();
            chk("hold_valid", rsp_valid, 1);
            chk("hold_ready", req_ready, 0);
         end
         rsp_ready = 1;
         tick();
         rsp_ready = 0;
         chk("rsp_drop", rsp_valid, 0);
      end
   endtask

   task automatic issue_clr();
      wait_ready(200);
      clr_start = 1;
      tick();
      clr_start = 0;
   endtask

   // Counts write strobes until the block is ready again.
   task automatic count_until_ready(output int wc, output int bc);
      int n = 0;
      wc = 0; bc = 0;
      while (!req_ready && n < 300) begin
         tick(); n++;
         if (ram_wren) wc++;
         if (busy) bc++;
      end
      chk("clear_timeout", req_ready, 1);
   endtask

   initial begin
      logic [DW-1:0] rd;
      int            lat, wc, bc, n;

      reset_n = 0; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
      rsp_ready = 0; clr_start = 0;
      repeat (3) tick();
      chk("rst_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wren", ram_wren, 0);
      chk("rst_rsp_valid", rsp_valid, 0);

      // Automatic clear after reset release.
      reset_n = 1;
      count_until_ready(wc, bc);
      chk("auto_clear_wren_cycles", wc, 64);
      chk("auto_clear_busy_cycles", bc, 64);
      issue(0, 6'h3F, '0, 0, 0, rd, lat);
      chk("rd_3f", rd, 16'h0000);

      // Back-to-back writes, then reads with latency check.
      issue(1, 6'd1, 16'h0002, 0, 0, rd, lat);
      issue(1, 6'd3, 16'h0004, 0, 0, rd, lat);
      issue(0, 6'd1, '0, 0, 0, rd, lat);
      chk("rd_1", rd, 16'h0002);
      chk("rd_1_latency", lat, RD_LAT + 1);
      issue(0, 6'd3, '0, 0, 0, rd, lat);
      chk("rd_3", rd, 16'h0004);
      chk("rd_3_latency", lat, RD_LAT + 1);

      // Read immediately after write to the same address.
      issue(1, 6'd1, 16'h0006, 0, 0, rd, lat);
      issue(0, 6'd1, '0, 0, 0, rd, lat);
      chk("raw_1", rd, 16'h0006);

      // Response held for 5 clocks of backpressure.
      issue(0, 6'd3, '0, 0, 5, rd, lat);
      chk("held_rd_3", rsp_rdata, 16'h0004);

      // Clear requested together with a write: write first, then full clear.
      issue(1, 6'd5, 16'h1234, 1, 0, rd, lat);
      count_until_ready(wc, bc);
      chk("pend_clear_wren_cycles", wc, 64);
      issue(0, 6'd5, '0, 0, 0, rd, lat);
      chk("rd_5_cleared", rd, 16'h0000);

      // Reset in the middle of a clear.
      issue_clr();
      n = 0;
      while (!(ram_wren && ram_address == 6'd20) && n < 200) begin tick(); n++; end
      chk("clear_idx20_seen", ram_address, 20);
      reset_n = 0;
      tick();
      chk("abort_wren", ram_wren, 0);
      chk("abort_busy", busy, 0);
      tick();
      reset_n = 1;
      n = 0;
      while (!ram_wren && n < 10) begin tick(); n++; end
      chk("restart_addr", ram_address, 0);
      wait_ready(200);

      // Randomized traffic checked by the model.
      for (int i = 0; i < 300; i++) begin
         int            r;
         logic [AW-1:0] a;
         r = $urandom_range(0, 19);
         a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
         if (r < 8) begin
            issue(1, a, DW'($urandom), 0, 0, rd, lat);
         end else if (r < 16) begin
            issue(0, a, '0, 0, $urandom_range(0, 3), rd, lat);
         end else if (r == 16) begin
            issue_clr();
         end else if (r == 17) begin
            issue($urandom_range(0, 1) == 1, a, DW'($urandom), 1, 0, rd, lat);
         end else begin
            repeat ($urandom_range(1, 3)) tick();
         end
      end
      wait_ready(200);
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
